// File: rtl/fm_brg_arb.sv
// Two-requester round-robin arbiter in front of the internal-bus bridge.
// Holds the grant through the write burst and steers read beats back in issue order.
`timescale 1ns/1ps
module fm_brg_arb #(
  parameter int P_IB_ADDR_WIDTH = 29,
  parameter int P_IB_LEN_WIDTH  = 6,
  parameter int P_IB_DATA_WIDTH = 64,
  parameter int P_ORD_DEPTH     = 4
) (
  input  logic                       clk_core,
  input  logic                       rst_x,
  input  logic                       i_req0,
  input  logic [P_IB_ADDR_WIDTH-1:0] i_adrs0,
  input  logic                       i_rw0,
  input  logic [P_IB_LEN_WIDTH-1:0]  i_len0,
  output logic                       o_ack0,
  input  logic                       i_req1,
  input  logic [P_IB_ADDR_WIDTH-1:0] i_adrs1,
  input  logic                       i_rw1,
  input  logic [P_IB_LEN_WIDTH-1:0]  i_len1,
  output logic                       o_ack1,
  input  logic [P_IB_DATA_WIDTH-1:0] i_wd0,
  input  logic                       i_wstr0,
  output logic                       o_wack0,
  input  logic [P_IB_DATA_WIDTH-1:0] i_wd1,
  input  logic                       i_wstr1,
  output logic                       o_wack1,
  output logic                       o_rstr0,
  output logic [P_IB_DATA_WIDTH-1:0] o_rd0,
  output logic                       o_rstr1,
  output logic [P_IB_DATA_WIDTH-1:0] o_rd1,
  output logic                       o_brg_req,
  output logic [P_IB_ADDR_WIDTH-1:0] o_brg_adrs,
  output logic                       o_brg_rw,
  output logic [P_IB_LEN_WIDTH-1:0]  o_brg_len,
  input  logic                       i_brg_ack,
  output logic                       o_brg_wstr,
  output logic [P_IB_DATA_WIDTH-1:0] o_brg_wd,
  input  logic                       i_brg_wack,
  input  logic                       i_brg_rstr,
  input  logic [P_IB_DATA_WIDTH-1:0] i_brg_rd
);

  localparam int LP_PW = (P_ORD_DEPTH > 1) ? $clog2(P_ORD_DEPTH) : 1;
  localparam logic [LP_PW:0] LP_FULL = (LP_PW+1)'(P_ORD_DEPTH);
  localparam logic [P_IB_LEN_WIDTH-1:0] LP_LEN_ONE = (P_IB_LEN_WIDTH)'(1);

  typedef enum logic [1:0] {P_IDLE, P_CMD, P_WDATA} state_t;

  state_t state, state_nx;
  logic   grant, grant_nx;
  logic   last_grant;
  logic [P_IB_LEN_WIDTH-1:0] wcnt;

  logic [P_IB_ADDR_WIDTH-1:0] sel_adrs;
  logic                       sel_rw;
  logic [P_IB_LEN_WIDTH-1:0]  sel_len;
  logic                       sel_wstr;
  logic [P_IB_DATA_WIDTH-1:0] sel_wd;

  logic in_cmd, in_wdata, cmd_live, cmd_fire, wbeat;

  logic                      fifo_id  [P_ORD_DEPTH];
  logic [P_IB_LEN_WIDTH-1:0] fifo_len [P_ORD_DEPTH];
  logic [LP_PW-1:0]          wr_ptr, rd_ptr;
  logic [LP_PW:0]            count;
  logic [P_IB_LEN_WIDTH-1:0] rcnt, rcnt_inc;
  logic fifo_full, fifo_empty, head_id, rbeat, push, pop;

  // Granted requester mux
  assign sel_adrs = grant ? i_adrs1 : i_adrs0;
  assign sel_rw   = grant ? i_rw1   : i_rw0;
  assign sel_len  = grant ? i_len1  : i_len0;
  assign sel_wstr = grant ? i_wstr1 : i_wstr0;
  assign sel_wd   = grant ? i_wd1   : i_wd0;

  assign in_cmd   = (state == P_CMD);
  assign in_wdata = (state == P_WDATA);

  assign fifo_full  = (count == LP_FULL);
  assign fifo_empty = (count == '0);

  // A read may only go out when its return routing can be recorded.
  assign cmd_live = in_cmd & ~(sel_rw & fifo_full);
  assign cmd_fire = cmd_live & i_brg_ack;

  assign o_brg_req  = cmd_live;
  assign o_brg_adrs = in_cmd ? sel_adrs : '0;
  assign o_brg_rw   = in_cmd & sel_rw;
  assign o_brg_len  = in_cmd ? sel_len : '0;
  assign o_ack0     = cmd_fire & ~grant;
  assign o_ack1     = cmd_fire &  grant;

  assign wbeat      = in_wdata & i_brg_wack;
  assign o_brg_wstr = in_wdata & sel_wstr;
  assign o_brg_wd   = in_wdata ? sel_wd : '0;
  assign o_wack0    = wbeat & ~grant;
  assign o_wack1    = wbeat &  grant;

  assign head_id  = fifo_id[rd_ptr];
  assign rbeat    = i_brg_rstr & ~fifo_empty;
  assign rcnt_inc = rcnt + 1'b1;
  assign push     = cmd_fire & sel_rw;
  assign pop      = rbeat & (rcnt_inc == fifo_len[rd_ptr]);

  assign o_rstr0 = rbeat & ~head_id;
  assign o_rstr1 = rbeat &  head_id;
  assign o_rd0   = i_brg_rd;
  assign o_rd1   = i_brg_rd;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    unique case (state)
      P_IDLE: begin
        if (i_req0 | i_req1) begin
          state_nx = P_CMD;
          grant_nx = (i_req0 & i_req1) ? ~last_grant : i_req1;
        end
      end
      P_CMD: begin
        if (cmd_fire) state_nx = sel_rw ? P_IDLE : P_WDATA;
      end
      P_WDATA: begin
        if (wbeat && (wcnt == LP_LEN_ONE)) state_nx = P_IDLE;
      end
      default: state_nx = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      state      <= P_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wcnt       <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (cmd_fire) last_grant <= grant;
      if (cmd_fire && !sel_rw) wcnt <= sel_len;
      else if (wbeat)          wcnt <= wcnt - 1'b1;
    end
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)        rcnt <= '0;
      else if (rbeat) rcnt <= rcnt_inc;
    end
  end

  always_ff @(posedge clk_core) begin
    if (push) begin
      fifo_id[wr_ptr]  <= grant;
      fifo_len[wr_ptr] <= sel_len;
    end
  end

endmodule

// File: tb/tb_fm_brg_arb.sv
// Scoreboard bench for fm_brg_arb: directed commands, bridge responders, negedge monitor.
`timescale 1ns/1ps
module tb_fm_brg_arb;

  localparam int AW = 29;
  localparam int LW = 6;
  localparam int DW = 64;

  typedef struct { logic [AW-1:0] adrs; logic rw; logic [LW-1:0] len; logic [DW-1:0] wbase; } cmd_t;
  typedef struct { int id; logic [AW-1:0] adrs; logic rw; logic [LW-1:0] len; } ack_t;
  typedef struct { int id; logic [DW-1:0] data; } beat_t;

  logic clk_core, rst_x;
  logic i_req0, i_rw0, i_wstr0, i_req1, i_rw1, i_wstr1;
  logic [AW-1:0] i_adrs0, i_adrs1;
  logic [LW-1:0] i_len0, i_len1;
  logic [DW-1:0] i_wd0, i_wd1;
  logic o_ack0, o_ack1, o_wack0, o_wack1, o_rstr0, o_rstr1;
  logic [DW-1:0] o_rd0, o_rd1, o_brg_wd, i_brg_rd;
  logic o_brg_req, o_brg_rw, i_brg_ack, o_brg_wstr, i_brg_wack, i_brg_rstr;
  logic [AW-1:0] o_brg_adrs;
  logic [LW-1:0] o_brg_len;

  fm_brg_arb #(.P_IB_ADDR_WIDTH(AW), .P_IB_LEN_WIDTH(LW), .P_IB_DATA_WIDTH(DW), .P_ORD_DEPTH(4)) dut (
    .clk_core(clk_core), .rst_x(rst_x),
    .i_req0(i_req0), .i_adrs0(i_adrs0), .i_rw0(i_rw0), .i_len0(i_len0), .o_ack0(o_ack0),
    .i_req1(i_req1), .i_adrs1(i_adrs1), .i_rw1(i_rw1), .i_len1(i_len1), .o_ack1(o_ack1),
    .i_wd0(i_wd0), .i_wstr0(i_wstr0), .o_wack0(o_wack0),
    .i_wd1(i_wd1), .i_wstr1(i_wstr1), .o_wack1(o_wack1),
    .o_rstr0(o_rstr0), .o_rd0(o_rd0), .o_rstr1(o_rstr1), .o_rd1(o_rd1),
    .o_brg_req(o_brg_req), .o_brg_adrs(o_brg_adrs), .o_brg_rw(o_brg_rw), .o_brg_len(o_brg_len),
    .i_brg_ack(i_brg_ack), .o_brg_wstr(o_brg_wstr), .o_brg_wd(o_brg_wd), .i_brg_wack(i_brg_wack),
    .i_brg_rstr(i_brg_rstr), .i_brg_rd(i_brg_rd)
  );

  int tests = 0;
  int fails = 0;
  cmd_t  q0[$], q1[$];
  ack_t  exp_ack[$];
  beat_t exp_wack[$], exp_rd[$];
  logic  ack_hit[2], wack_hit[2];
  logic  abort;
  int    wbeats_left = 0;
  int unsigned brg_delay;
  logic  wack_slow;

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic cmd_t qpop(input int id);
    return (id == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic set_req(input int id, input logic r, input cmd_t c);
    if (id == 0) begin i_req0 = r; i_adrs0 = c.adrs; i_rw0 = c.rw; i_len0 = c.len; end
    else         begin i_req1 = r; i_adrs1 = c.adrs; i_rw1 = c.rw; i_len1 = c.len; end
  endtask

  task automatic set_w(input int id, input logic s, input logic [DW-1:0] d);
    if (id == 0) begin i_wstr0 = s; i_wd0 = d; end
    else         begin i_wstr1 = s; i_wd1 = d; end
  endtask

  // Queue a command; acks are expected in issue order for every scenario below.
  task automatic issue(input int id, input logic [AW-1:0] adrs, input logic rw,
                       input logic [LW-1:0] len, input logic [DW-1:0] wbase);
    cmd_t c; ack_t a; beat_t b;
    c.adrs = adrs; c.rw = rw; c.len = len; c.wbase = wbase;
    a.id = id; a.adrs = adrs; a.rw = rw; a.len = len;
    if (id == 0) q0.push_back(c); else q1.push_back(c);
    exp_ack.push_back(a);
    if (!rw) for (int unsigned k = 0; k < len; k++) begin
      b.id = id; b.data = wbase + k; exp_wack.push_back(b);
    end
  endtask

  task automatic run_req(input int id);
    cmd_t c;
    int unsigned n;
    forever begin
      while (qsize(id) == 0) tick();
      c = qpop(id);
      set_req(id, 1'b1, c);
      n = 0;
      do begin tick(); n++; end while (!ack_hit[id] && !abort && n < 200);
      if (!ack_hit[id] && !abort) begin
        tests++; fails++;
        $display("FAIL ack_timeout req%0d got=none exp=ack", id);
      end
      set_req(id, 1'b0, c);
      if (!c.rw && !abort) for (int unsigned k = 0; k < c.len; k++) begin
        set_w(id, 1'b1, c.wbase + k);
        n = 0;
        do begin tick(); n++; end while (!wack_hit[id] && !abort && n < 200);
        if (!wack_hit[id] && !abort) begin
          tests++; fails++;
          $display("FAIL wack_timeout req%0d got=none exp=wack", id);
        end
        if (abort) break;
      end
      set_w(id, 1'b0, '0);
    end
  endtask

  initial run_req(0);
  initial run_req(1);

  // Bridge command side: acks a live request after brg_delay cycles.
  initial begin
    int unsigned cnt = 0;
    forever begin
      @(posedge clk_core); #2;
      if (!rst_x || i_brg_ack) begin i_brg_ack = 1'b0; cnt = 0; end
      else if (o_brg_req) begin
        if (cnt >= brg_delay) i_brg_ack = 1'b1; else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk_core); #2;
      if (!rst_x) i_brg_wack = 1'b0;
      else i_brg_wack = o_brg_wstr && !(wack_slow && i_brg_wack);
    end
  end

  initial begin
    ack_t a; beat_t b;
    forever begin
      @(negedge clk_core);
      ack_hit[0] = o_ack0;  ack_hit[1] = o_ack1;
      wack_hit[0] = o_wack0; wack_hit[1] = o_wack1;
      if (rst_x) begin
        if (o_ack0 | o_ack1) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", {o_ack1, o_ack0}, 2'b00);
          else begin
            a = exp_ack.pop_front();
            chk("ack_id", {o_ack1, o_ack0}, (a.id == 1) ? 2'b10 : 2'b01);
            chk("ack_cmd", {o_brg_adrs, o_brg_rw, o_brg_len}, {a.adrs, a.rw, a.len});
            chk("ack_during_wdata", wbeats_left, 0);
            if (!a.rw) wbeats_left += int'(a.len);
          end
        end
        if (o_wack0 | o_wack1) begin
          if (exp_wack.size() == 0) chk("wack_unexpected", {o_wack1, o_wack0}, 2'b00);
          else begin
            b = exp_wack.pop_front();
            chk("wack_id", {o_wack1, o_wack0}, (b.id == 1) ? 2'b10 : 2'b01);
            chk("wack_data", o_brg_wd, b.data);
            if (wbeats_left > 0) wbeats_left--;
          end
        end
        if (o_rstr0 | o_rstr1) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", {o_rstr1, o_rstr0}, 2'b00);
          else begin
            b = exp_rd.pop_front();
            chk("rd_id", {o_rstr1, o_rstr0}, (b.id == 1) ? 2'b10 : 2'b01);
            chk("rd_data", (b.id == 1) ? o_rd1 : o_rd0, b.data);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((exp_ack.size() != 0 || exp_wack.size() != 0) && n < 300) begin tick(); n++; end
    chk({name, "_drain"}, exp_ack.size() + exp_wack.size(), 0);
  endtask

  task automatic ret(input int id, input logic [DW-1:0] d);
    beat_t b;
    b.id = id; b.data = d;
    exp_rd.push_back(b);
    i_brg_rstr = 1'b1; i_brg_rd = d;
    tick();
    i_brg_rstr = 1'b0; i_brg_rd = '0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {o_ack0, o_ack1, o_wack0, o_wack1, o_rstr0, o_rstr1, o_brg_req, o_brg_adrs,
               o_brg_rw, o_brg_len, o_brg_wstr, o_brg_wd}, '0);
    chk({name, "_rd"}, o_rd0 | o_rd1, '0);
  endtask

  initial begin
    int unsigned n;
    {i_req0, i_rw0, i_wstr0, i_req1, i_rw1, i_wstr1} = '0;
    {i_adrs0, i_adrs1, i_len0, i_len1, i_wd0, i_wd1} = '0;
    {i_brg_ack, i_brg_wack, i_brg_rstr} = '0;
    i_brg_rd = '0;
    rst_x = 1'b0; abort = 1'b0; brg_delay = 1; wack_slow = 1'b0;
    #1;
    chk_reset_outputs("reset_outputs");
    repeat (3) tick();
    rst_x = 1'b1;

    // Both request at reset exit: strict alternation 0,1,0,1.
    issue(0, 29'h010, 1'b1, 6'd1, '0);
    issue(1, 29'h020, 1'b1, 6'd1, '0);
    issue(0, 29'h030, 1'b1, 6'd1, '0);
    issue(1, 29'h040, 1'b1, 6'd1, '0);
    wait_drain("arb");
    ret(0, 64'h1111); ret(1, 64'h2222); ret(0, 64'h3333); ret(1, 64'h4444);
    tick(); chk("arb_rd_done", exp_ack.size() + exp_rd.size(), 0);

    // Single read, slower bridge ack, four return beats.
    brg_delay = 2;
    issue(0, 29'h100, 1'b1, 6'd4, '0);
    wait_drain("rd4");
    brg_delay = 1;
    for (int unsigned i = 0; i < 4; i++) ret(0, 64'hA0 + i);
    tick(); chk("rd4_done", exp_rd.size(), 0);

    // Read0 len 2 then read1 len 1: beats routed 0,0,1.
    issue(0, 29'h200, 1'b1, 6'd2, '0);
    repeat (3) tick();
    issue(1, 29'h210, 1'b1, 6'd1, '0);
    wait_drain("ilv");
    ret(0, 64'hC0); ret(0, 64'hC1); ret(1, 64'hC2);
    tick(); chk("ilv_done", exp_rd.size(), 0);

    // Write1 len 3 with wack every other cycle; read0 must wait for the burst.
    wack_slow = 1'b1;
    issue(1, 29'h080, 1'b0, 6'd3, 64'hB000);
    repeat (2) tick();
    issue(0, 29'h090, 1'b1, 6'd1, '0);
    wait_drain("wr3");
    wack_slow = 1'b0;
    ret(0, 64'hD0);
    tick(); chk("wr3_done", exp_rd.size(), 0);

    // Five reads with no returns: fifth stalls until a beat pops the FIFO.
    for (int unsigned i = 0; i < 5; i++) issue(0, 29'h300 + i, 1'b1, 6'd1, '0);
    n = 0;
    while (exp_ack.size() > 1 && n < 300) begin tick(); n++; end
    chk("full_four_acks", exp_ack.size(), 1);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("full_stall_req", o_brg_req, 1'b0);
    end
    chk("full_no_fifth_ack", exp_ack.size(), 1);
    ret(0, 64'hE0);
    wait_drain("full");
    for (int unsigned i = 1; i < 5; i++) ret(0, 64'hE0 + i);
    tick(); chk("full_done", exp_rd.size(), 0);

    // Reset in the middle of a write burst with one read outstanding.
    issue(0, 29'h400, 1'b1, 6'd1, '0);
    wait_drain("rst_rd");
    issue(1, 29'h410, 1'b0, 6'd3, 64'hF000);
    n = 0;
    while (wbeats_left != 2 && n < 300) begin tick(); n++; end
    chk("rst_wcnt2", wbeats_left, 2);
    abort = 1'b1;
    #2 rst_x = 1'b0;
    #1 chk_reset_outputs("async_reset_outputs");
    exp_wack.delete();
    wbeats_left = 0;
    repeat (3) tick();
    rst_x = 1'b1;
    tick();
    abort = 1'b0;
    i_brg_rstr = 1'b1; i_brg_rd = 64'hDEAD;
    #1 chk("post_reset_fifo_empty", {o_rstr1, o_rstr0}, 2'b00);
    tick();
    i_brg_rstr = 1'b0; i_brg_rd = '0;
    issue(0, 29'h500, 1'b1, 6'd1, '0);
    issue(1, 29'h600, 1'b1, 6'd1, '0);
    wait_drain("post_reset_arb");
    ret(0, 64'h50); ret(1, 64'h60);
    tick();

    chk("end_queues", exp_ack.size() + exp_wack.size() + exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
